// File: rtl/scmi_irq_pkg.sv
// Shared types and defaults for the SCMI mailbox interrupt gate.
// Pure declarations: no latency, no backpressure.
package scmi_irq_pkg;

    localparam int unsigned NUM_CHANNELS_DEF  = 4;
    localparam int unsigned TIMEOUT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        DB_IDLE    = 2'd0,
        DB_PEND    = 2'd1,
        DB_EXPIRED = 2'd2
    } db_state_e;

endpackage

// File: rtl/scmi_irq_chan.sv
// One mailbox channel: doorbell FSM with wait counter and overrun flag, plus completion flag.
// Latency 1 cycle from pulse/ack to flags; no backpressure (pulse inputs, level outputs).
module scmi_irq_chan
    import scmi_irq_pkg::*;
#(
    parameter int unsigned TimeoutWidth = TIMEOUT_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    db_pulse,
    input  logic                    cmp_pulse,
    input  logic                    db_ack,
    input  logic                    cmp_ack,
    input  logic [TimeoutWidth-1:0] timeout,
    output logic                    db_pending,
    output logic                    cmp_pending,
    output logic                    db_overrun,
    output logic                    expired
);

    localparam logic [TimeoutWidth-1:0] CNT_MAX = '1;
    localparam logic [TimeoutWidth-1:0] CNT_ONE = TimeoutWidth'(1);

    db_state_e               state_q, state_d;
    logic [TimeoutWidth-1:0] cnt_q, cnt_d;
    logic                    ovr_q, ovr_d;
    logic                    cmp_q, cmp_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            cmp_q   <= cmp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        // A new completion wins over an acknowledge in the same cycle.
        cmp_d   = cmp_pulse | (cmp_q & ~cmp_ack);
        case (state_q)
            DB_IDLE: begin
                cnt_d = '0;
                if (db_pulse) begin
                    state_d = DB_PEND;
                end
            end
            DB_PEND, DB_EXPIRED: begin
                if (db_ack) begin
                    // Ack with a fresh pulse re-arms the channel rather than dropping it.
                    ovr_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = db_pulse ? DB_PEND : DB_IDLE;
                end else begin
                    if (db_pulse) begin
                        ovr_d = 1'b1;
                    end
                    if (state_q == DB_PEND) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        // >= so a threshold lowered mid-wait still fires at once.
                        if ((timeout != '0) && (cnt_q >= timeout - CNT_ONE)) begin
                            state_d = DB_EXPIRED;
                        end
                    end
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
                ovr_d   = 1'b0;
            end
        endcase
    end

    assign db_pending  = (state_q != DB_IDLE);
    assign expired     = (state_q == DB_EXPIRED);
    assign db_overrun  = ovr_q;
    assign cmp_pending = cmp_q;

endmodule

// File: rtl/scmi_irq_gate.sv
// SCMI doorbell/completion interrupt gate: per-channel pending state reduced to three level irqs.
// Latency 1 cycle pulse to irq, masks combinational; no backpressure.
module scmi_irq_gate
    import scmi_irq_pkg::*;
#(
    parameter int unsigned NumChannels  = NUM_CHANNELS_DEF,
    parameter int unsigned TimeoutWidth = TIMEOUT_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumChannels-1:0]  doorbell_pulse_i,
    input  logic [NumChannels-1:0]  completion_pulse_i,
    input  logic [NumChannels-1:0]  db_en_i,
    input  logic [NumChannels-1:0]  cmp_en_i,
    input  logic [NumChannels-1:0]  db_ack_i,
    input  logic [NumChannels-1:0]  cmp_ack_i,
    input  logic [TimeoutWidth-1:0] timeout_i,
    output logic [NumChannels-1:0]  db_pending_o,
    output logic [NumChannels-1:0]  cmp_pending_o,
    output logic [NumChannels-1:0]  db_overrun_o,
    output logic [NumChannels-1:0]  timeout_ch_o,
    output logic                    db_irq_o,
    output logic                    cmp_irq_o,
    output logic                    timeout_irq_o
);

    for (genvar g = 0; g < NumChannels; g++) begin : g_chan
        scmi_irq_chan #(
            .TimeoutWidth (TimeoutWidth)
        ) u_chan (
            .clk         (clk_i),
            .rst_n       (rst_ni),
            .db_pulse    (doorbell_pulse_i[g]),
            .cmp_pulse   (completion_pulse_i[g]),
            .db_ack      (db_ack_i[g]),
            .cmp_ack     (cmp_ack_i[g]),
            .timeout     (timeout_i),
            .db_pending  (db_pending_o[g]),
            .cmp_pending (cmp_pending_o[g]),
            .db_overrun  (db_overrun_o[g]),
            .expired     (timeout_ch_o[g])
        );
    end

    // Masks only gate the irq lines; channel state ignores them.
    assign db_irq_o      = |(db_pending_o & db_en_i);
    assign cmp_irq_o     = |(cmp_pending_o & cmp_en_i);
    assign timeout_irq_o = |timeout_ch_o;

endmodule

// File: tb/tb_scmi_irq_gate.sv
// Bench for scmi_irq_gate: reference model feeds a scoreboard checked every cycle, plus directed scenarios.
module tb_scmi_irq_gate;

    localparam int N  = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  db_pulse, cmp_pulse, db_en, cmp_en, db_ack, cmp_ack;
    logic [TW-1:0] timeout;
    logic [N-1:0]  db_pending, cmp_pending, db_overrun, timeout_ch;
    logic          db_irq, cmp_irq, timeout_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scmi_irq_gate #(.NumChannels(N), .TimeoutWidth(TW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .doorbell_pulse_i   (db_pulse),
        .completion_pulse_i (cmp_pulse),
        .db_en_i            (db_en),
        .cmp_en_i           (cmp_en),
        .db_ack_i           (db_ack),
        .cmp_ack_i          (cmp_ack),
        .timeout_i          (timeout),
        .db_pending_o       (db_pending),
        .cmp_pending_o      (cmp_pending),
        .db_overrun_o       (db_overrun),
        .timeout_ch_o       (timeout_ch),
        .db_irq_o           (db_irq),
        .cmp_irq_o          (cmp_irq),
        .timeout_irq_o      (timeout_irq)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: per-channel pending/expired flags and cycles-pending age.
    typedef struct {
        logic [N-1:0] dbp;
        logic [N-1:0] cmpp;
        logic [N-1:0] ovr;
        logic [N-1:0] tmo;
    } exp_t;

    exp_t sb_q[$];
    bit   m_pend[N], m_exp[N], m_ovr[N], m_cmp[N];
    int   m_age[N];

    always @(posedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_pend[i] = 0; m_exp[i] = 0; m_ovr[i] = 0; m_cmp[i] = 0; m_age[i] = 0;
            end else begin
                if (!m_pend[i]) begin
                    if (db_pulse[i]) begin m_pend[i] = 1; m_age[i] = 0; end
                end else if (db_ack[i]) begin
                    m_ovr[i] = 0; m_age[i] = 0; m_exp[i] = 0; m_pend[i] = db_pulse[i];
                end else begin
                    if (db_pulse[i]) m_ovr[i] = 1;
                    if (!m_exp[i]) begin
                        if (m_age[i] < 65535) m_age[i]++;
                        if (timeout != 0 && m_age[i] >= int'(timeout)) m_exp[i] = 1;
                    end
                end
                m_cmp[i] = cmp_pulse[i] | (m_cmp[i] & ~cmp_ack[i]);
            end
            e.dbp[i]  = m_pend[i];
            e.cmpp[i] = m_cmp[i];
            e.ovr[i]  = m_ovr[i];
            e.tmo[i]  = m_exp[i];
        end
        sb_q.push_back(e);
    end

    // Monitor: outputs are presented every cycle, compared mid-cycle against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_db_pending",  32'(db_pending),  32'(e.dbp));
            chk("sb_cmp_pending", 32'(cmp_pending), 32'(e.cmpp));
            chk("sb_db_overrun",  32'(db_overrun),  32'(e.ovr));
            chk("sb_timeout_ch",  32'(timeout_ch),  32'(e.tmo));
            chk("sb_db_irq",      32'(db_irq),      32'(|(e.dbp & db_en)));
            chk("sb_cmp_irq",     32'(cmp_irq),     32'(|(e.cmpp & cmp_en)));
            chk("sb_timeout_irq", 32'(timeout_irq), 32'(|e.tmo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_pulses();
        db_pulse = '0; cmp_pulse = '0; db_ack = '0; cmp_ack = '0;
    endtask

    initial begin
        rst_n = 1'b0; timeout = '0; db_en = '0; cmp_en = '0;
        clear_pulses();
        tick(); tick();
        chk("reset_db_pending", 32'(db_pending), 0);
        chk("reset_irqs", {29'd0, db_irq, cmp_irq, timeout_irq}, 0);
        rst_n = 1'b1;

        // Doorbell raise and acknowledge on channel 0.
        db_en = 4'b0001; db_pulse = 4'b0001; tick(); clear_pulses();
        chk("db0_pending", 32'(db_pending), 32'h1);
        chk("db0_irq", 32'(db_irq), 1);
        db_ack = 4'b0001; tick(); clear_pulses();
        chk("db0_ack_pending", 32'(db_pending), 0);
        chk("db0_ack_irq", 32'(db_irq), 0);

        // Overrun on channel 2, sticky until ack; pulse+ack re-arms without overrun.
        db_pulse = 4'b0100; tick(); clear_pulses(); tick();
        db_pulse = 4'b0100; tick(); clear_pulses();
        chk("ovr2_set", 32'(db_overrun[2]), 1);
        repeat (3) tick();
        chk("ovr2_sticky", 32'(db_overrun[2]), 1);
        db_pulse = 4'b0100; db_ack = 4'b0100; tick(); clear_pulses();
        chk("ovr2_rearm_pending", 32'(db_pending[2]), 1);
        chk("ovr2_rearm_overrun", 32'(db_overrun[2]), 0);
        db_ack = 4'b0100; tick(); clear_pulses();
        chk("ovr2_idle", 32'(db_pending[2]), 0);

        // Ack while idle has no effect.
        db_ack = 4'b1111; tick(); clear_pulses();
        chk("ack_idle", {db_pending, db_overrun}, 0);

        // Timeout fires exactly 5 cycles after pending rises.
        timeout = 16'd5; db_pulse = 4'b0010; tick(); clear_pulses();
        chk("tmo_pending", 32'(db_pending[1]), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("tmo_early_%0d", k), 32'(timeout_ch[1]), 0);
        end
        tick();
        chk("tmo_fire_ch", 32'(timeout_ch[1]), 1);
        chk("tmo_fire_irq", 32'(timeout_irq), 1);
        db_ack = 4'b0010; tick(); clear_pulses();
        chk("tmo_ack", {db_pending, timeout_ch}, 0);

        // Timeout disabled: never expires.
        timeout = '0; db_pulse = 4'b0010; tick(); clear_pulses();
        repeat (1000) tick();
        chk("tmo_off_ch", 32'(timeout_ch), 0);
        chk("tmo_off_irq", 32'(timeout_irq), 0);
        db_ack = 4'b0010; tick(); clear_pulses();

        // Completion pending is independent of its mask; mask gates irq combinationally.
        cmp_en = '0; cmp_pulse = 4'b1000; tick(); clear_pulses();
        chk("cmp3_pending", 32'(cmp_pending[3]), 1);
        chk("cmp3_irq_masked", 32'(cmp_irq), 0);
        cmp_en = 4'b1000; #1;
        chk("cmp3_irq_unmasked", 32'(cmp_irq), 1);
        cmp_pulse = 4'b1000; cmp_ack = 4'b1000; tick(); clear_pulses();
        chk("cmp3_set_wins", 32'(cmp_pending[3]), 1);
        cmp_ack = 4'b1000; tick(); clear_pulses();
        chk("cmp3_cleared", 32'(cmp_pending[3]), 0);

        // Mid-operation reset discards everything, including pulses in the reset cycle.
        db_en = '1; timeout = 16'd3; db_pulse = '1; cmp_pulse = '1; tick(); clear_pulses();
        db_pulse = '1; tick(); clear_pulses();
        chk("pre_rst_pending", 32'(db_pending), 32'hF);
        rst_n = 1'b0; db_pulse = 4'b0101; cmp_pulse = '1; tick(); clear_pulses(); rst_n = 1'b1;
        chk("rst_flags", {db_pending, cmp_pending, db_overrun, timeout_ch}, 0);
        chk("rst_irqs", {29'd0, db_irq, cmp_irq, timeout_irq}, 0);
        tick();
        chk("rst_pulse_dropped", 32'(db_pending), 0);

        // Randomized traffic checked by the scoreboard.
        timeout = 16'($urandom_range(0, 8));
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) timeout = 16'($urandom_range(0, 8));
            for (int i = 0; i < N; i++) begin
                db_pulse[i]  = ($urandom_range(0, 7) == 0);
                cmp_pulse[i] = ($urandom_range(0, 7) == 0);
                db_ack[i]    = ($urandom_range(0, 9) == 0);
                cmp_ack[i]   = ($urandom_range(0, 5) == 0);
            end
            db_en  = N'($urandom);
            cmp_en = N'($urandom);
            rst_n  = ($urandom_range(0, 499) != 0);
            tick();
        end
        clear_pulses(); rst_n = 1'b1;
        tick(); tick();
        @(negedge clk); #1;
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scmi_irq_gate.md
SCMI_IRQ_GATE -- requirements
Module: scmi_irq_gate

Interface
REQ-001 Parameter NumChannels, default 4: number of SCMI mailbox channels served, legal range 1..32.
REQ-002 Parameter TimeoutWidth, default 16: width of timeout threshold and per-channel wait counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 doorbell_pulse_i  input  NumChannels  single-cycle doorbell events, one bit per mailbox instance.
REQ-006 completion_pulse_i  input  NumChannels  single-cycle completion events, one bit per mailbox instance.
REQ-007 db_en_i  input  NumChannels  doorbell interrupt enable mask.
REQ-008 cmp_en_i  input  NumChannels  completion interrupt enable mask.
REQ-009 db_ack_i  input  NumChannels  single-cycle doorbell acknowledge from the platform-side handler.
REQ-010 cmp_ack_i  input  NumChannels  single-cycle completion acknowledge from the agent-side handler.
REQ-011 timeout_i  input  TimeoutWidth  doorbell service deadline in cycles; 0 disables timeout.
REQ-012 db_pending_o  output  NumChannels  latched doorbell pending flags.
REQ-013 cmp_pending_o  output  NumChannels  latched completion pending flags.
REQ-014 db_overrun_o  output  NumChannels  sticky flag: doorbell arrived while already pending.
REQ-015 timeout_ch_o  output  NumChannels  sticky flag: doorbell left unacknowledged past deadline.
REQ-016 db_irq_o  output  1  level interrupt, OR over (db_pending_o AND db_en_i).
REQ-017 cmp_irq_o  output  1  level interrupt, OR over (cmp_pending_o AND cmp_en_i).
REQ-018 timeout_irq_o  output  1  level interrupt, OR over timeout_ch_o.

Function
REQ-019 Each channel SHALL run a doorbell FSM with states IDLE, PEND, EXPIRED; db_pending_o[i] = (state != IDLE), timeout_ch_o[i] = (state == EXPIRED).
REQ-020 IDLE -> PEND on doorbell_pulse_i[i]; pending visible the following cycle (1-cycle latency pulse to db_irq_o).
REQ-021 PEND or EXPIRED -> IDLE on db_ack_i[i] with no simultaneous pulse; db_overrun_o[i] cleared in the same update.
REQ-022 Pulse and ack in the same cycle while PEND/EXPIRED: state -> PEND, wait counter restarts at 0, overrun cleared, no overrun set.
REQ-023 Pulse without ack while PEND/EXPIRED: state unchanged, db_overrun_o[i] set to 1.
REQ-024 Ack while IDLE: no effect, no error flag.
REQ-025 Wait counter SHALL be 0 in IDLE, increment by 1 each cycle in PEND, and saturate at all-ones.
REQ-026 PEND -> EXPIRED in the cycle after the counter equals timeout_i - 1 with timeout_i != 0 (i.e. after timeout_i cycles pending); timeout_i changes take effect immediately.
REQ-027 Completion path SHALL be a 1-bit pending flag per channel: set on pulse, cleared on ack, set wins when both occur together.
REQ-028 Enable masks SHALL gate only the irq outputs; pending, overrun and timeout state evolve regardless of masks.
REQ-029 Irq outputs SHALL be combinational from registered state and current masks; no glitch-free requirement beyond that.

Reset
REQ-030 On rst_ni low at a clock edge: all FSMs IDLE, counters 0, all pending/overrun/timeout flags 0, all irq outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard pending events; pulses in the reset cycle SHALL be ignored.

Structure
REQ-032 Package scmi_irq_pkg SHALL hold the doorbell FSM state enum and default values for NumChannels and TimeoutWidth.
REQ-033 One sub-module scmi_irq_chan SHALL implement one channel (FSM, counter, overrun, completion flag); the top SHALL instantiate NumChannels copies and reduce the irq ORs.

Verification
REQ-034 Reset, then doorbell_pulse_i=4'b0001 with db_en_i=4'b0001 -> db_pending_o=4'b0001 and db_irq_o=1 one cycle later; db_ack_i=4'b0001 -> both 0 next cycle.
REQ-035 Two doorbell pulses on ch2 without ack -> db_overrun_o[2]=1, stays 1 until db_ack_i[2]; simultaneous pulse+ack -> pending 1, overrun 0.
REQ-036 timeout_i=5, pulse ch1, no ack -> timeout_ch_o[1]=1 and timeout_irq_o=1 exactly 5 cycles after pending rises; timeout_i=0 repeat -> never set after 1000 cycles.
REQ-037 cmp_en_i=0, completion pulse ch3 -> cmp_pending_o[3]=1, cmp_irq_o=0; set cmp_en_i[3]=1 -> cmp_irq_o=1 same cycle.
REQ-038 All channels pending, rst_ni low for one cycle mid-operation -> every output 0 the next cycle, pulse in reset cycle not captured.
